// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for the SRAM slave.
// Signal suffixes are from the slave's point of view.
interface ahb_sram_slave_if;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [1:0]  htrans_i;
    logic        hwrite_i;
    logic [31:0] hwdata_i;
    logic        hready_i;
    logic [31:0] hrdata_o;
    logic        hready_o;
    logic [1:0]  hresp_o;

    modport slave (
        input  hsel_i, haddr_i, htrans_i, hwrite_i, hwdata_i, hready_i,
        output hrdata_o, hready_o, hresp_o
    );

    modport master (
        output hsel_i, haddr_i, htrans_i, hwrite_i, hwdata_i, hready_i,
        input  hrdata_o, hready_o, hresp_o
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-addressed SRAM slave with programmable wait states and
// two-cycle ERROR response for misaligned or out-of-window addresses.
//
// state    | meaning
// ST_IDLE  | no data phase pending (ready, OKAY)
// ST_WAIT  | data phase stalled, counting wait states (not ready, OKAY)
// ST_DATA  | data phase completes this cycle (ready, OKAY)
// ST_ERR1  | first ERROR cycle (not ready, ERROR)
// ST_ERR2  | second ERROR cycle (ready, ERROR)
module ahb_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h1A00,
    parameter int          MEM_DEPTH   = 128,
    parameter int          WAIT_STATES = 1
) (
    input  logic              hclk_i,
    input  logic              irst_n,
    ahb_sram_slave_if.slave   bus
);

    localparam int          AW         = $clog2(MEM_DEPTH);
    localparam logic [31:0] ADDR_SPAN  = 32'(4 * MEM_DEPTH);
    localparam logic [2:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic          write_q;
    logic [AW-1:0] idx_q;
    logic          hready_q;
    logic [1:0]    hresp_q;

    logic [31:0]   mem [MEM_DEPTH];

    logic          accept;
    logic [31:0]   addr_off;
    logic          addr_bad;
    logic [AW-1:0] addr_idx;

    assign accept   = bus.hsel_i & bus.hready_i & bus.htrans_i[1];
    // Unsigned offset wraps for addresses below the base, so one compare covers both window edges.
    assign addr_off = bus.haddr_i - ADDR_BASE;
    assign addr_bad = (addr_off[1:0] != 2'b00) || (addr_off >= ADDR_SPAN);
    assign addr_idx = addr_off[AW+1:2];

    always_ff @(posedge hclk_i or negedge irst_n) begin
        if (!irst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        write_q <= bus.hwrite_i;
                        idx_q   <= addr_idx;
                        if (addr_bad) begin
                            state_q  <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= RESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state_q  <= ST_DATA;
                            hready_q <= 1'b1;
                            hresp_q  <= RESP_OKAY;
                        end else begin
                            state_q  <= ST_WAIT;
                            cnt_q    <= WAIT_LOAD;
                            hready_q <= 1'b0;
                            hresp_q  <= RESP_OKAY;
                        end
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= RESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q  <= ST_DATA;
                        hready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= RESP_ERROR;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= RESP_OKAY;
                end
            endcase
        end
    end

    // Storage has no reset; an async reset forces ST_IDLE first, which cancels any pending write.
    always_ff @(posedge hclk_i) begin
        if (state_q == ST_DATA && write_q) begin
            mem[idx_q] <= bus.hwdata_i;
        end
    end

    assign bus.hrdata_o = (state_q == ST_DATA && !write_q) ? mem[idx_q] : 32'h0;
    assign bus.hready_o = hready_q;
    assign bus.hresp_o  = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with zero wait states and
// one with a single wait state, driven from a per-cycle vector table.
module tb_ahb_sram_slave;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    typedef struct {
        bit          dut;
        bit          sel;
        logic [1:0]  tr;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          rdy;
        bit          e_rdy;
        logic [1:0]  e_resp;
        logic [31:0] e_rd;
    } vec_t;

    logic        hclk = 1'b0;
    logic        irst_n;
    logic        d_dut;
    logic        d_sel;
    logic [1:0]  d_tr;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wd;
    logic        d_rdy;

    int n_chk = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 hclk = ~hclk;

    ahb_sram_slave_if b0 ();
    ahb_sram_slave_if b1 ();

    assign b0.hsel_i   = d_sel & ~d_dut;
    assign b0.haddr_i  = d_addr;
    assign b0.htrans_i = d_tr;
    assign b0.hwrite_i = d_wr;
    assign b0.hwdata_i = d_wd;
    assign b0.hready_i = d_rdy;

    assign b1.hsel_i   = d_sel & d_dut;
    assign b1.haddr_i  = d_addr;
    assign b1.htrans_i = d_tr;
    assign b1.hwrite_i = d_wr;
    assign b1.hwdata_i = d_wd;
    assign b1.hready_i = d_rdy;

    ahb_sram_slave #(.ADDR_BASE(32'h1A00), .MEM_DEPTH(128), .WAIT_STATES(0)) u_ws0 (
        .hclk_i (hclk),
        .irst_n (irst_n),
        .bus    (b0)
    );

    ahb_sram_slave #(.ADDR_BASE(32'h1A00), .MEM_DEPTH(128), .WAIT_STATES(1)) u_ws1 (
        .hclk_i (hclk),
        .irst_n (irst_n),
        .bus    (b1)
    );

    wire        o_rdy  = d_dut ? b1.hready_o : b0.hready_o;
    wire [1:0]  o_resp = d_dut ? b1.hresp_o  : b0.hresp_o;
    wire [31:0] o_rd   = d_dut ? b1.hrdata_o : b0.hrdata_o;

    task automatic check(input string name, input bit e_rdy, input logic [1:0] e_resp,
                         input logic [31:0] e_rd);
        n_chk += 3;
        if (o_rdy !== e_rdy) begin
            n_bad++;
            $display("FAIL %s hready_o got %0b want %0b", name, o_rdy, e_rdy);
        end
        if (o_resp !== e_resp) begin
            n_bad++;
            $display("FAIL %s hresp_o got %0b want %0b", name, o_resp, e_resp);
        end
        if (o_rd !== e_rd) begin
            n_bad++;
            $display("FAIL %s hrdata_o got %0h want %0h", name, o_rd, e_rd);
        end
    endtask

    task automatic add(input bit dut, input bit sel, input logic [1:0] tr, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wd, input bit rdy,
                       input bit e_rdy, input logic [1:0] e_resp, input logic [31:0] e_rd);
        vec_t v;
        v.dut = dut; v.sel = sel; v.tr = tr; v.wr = wr; v.addr = addr; v.wd = wd;
        v.rdy = rdy; v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_rd = e_rd;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, then check the outputs of the following cycle.
    task automatic step(input vec_t v, input string name);
        d_dut  = v.dut;
        d_sel  = v.sel;
        d_tr   = v.tr;
        d_wr   = v.wr;
        d_addr = v.addr;
        d_wd   = v.wd;
        d_rdy  = v.rdy;
        @(posedge hclk);
        #1;
        check(name, v.e_rdy, v.e_resp, v.e_rd);
    endtask

    initial begin
        vec_t v;
        irst_n = 1'b0;
        d_dut = 1'b0; d_sel = 1'b0; d_tr = T_IDLE; d_wr = 1'b0;
        d_addr = 32'h0; d_wd = 32'h0; d_rdy = 1'b1;

        repeat (2) @(posedge hclk);
        #1;
        d_dut = 1'b0; #1; check("reset_ws0", 1'b1, 2'b00, 32'h0);
        d_dut = 1'b1; #1; check("reset_ws1", 1'b1, 2'b00, 32'h0);
        irst_n = 1'b1;
        @(posedge hclk);
        #1;

        // Zero wait states: preload burst, read burst, write-then-read hazard.
        add(0, 1, T_NSEQ, 1, 32'h1A00, 32'h0,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_SEQ,  1, 32'h1A04, 32'h1,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_SEQ,  1, 32'h1A08, 32'h2,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_SEQ,  1, 32'h1A0C, 32'h3,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_IDLE, 0, 32'h0,    32'h4,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_NSEQ, 0, 32'h1A00, 32'h0,  1, 1, 2'b00, 32'h1);
        add(0, 1, T_SEQ,  0, 32'h1A04, 32'h0,  1, 1, 2'b00, 32'h2);
        add(0, 1, T_SEQ,  0, 32'h1A08, 32'h0,  1, 1, 2'b00, 32'h3);
        add(0, 1, T_SEQ,  0, 32'h1A0C, 32'h0,  1, 1, 2'b00, 32'h4);
        add(0, 1, T_IDLE, 0, 32'h0,    32'h0,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_NSEQ, 1, 32'h1A10, 32'h0,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_NSEQ, 0, 32'h1A10, 32'h55, 1, 1, 2'b00, 32'h55);
        add(0, 1, T_IDLE, 0, 32'h0,    32'h0,  1, 1, 2'b00, 32'h0);
        // Errors: out of range, misaligned, then a valid read straight from ST_ERR2.
        add(0, 1, T_NSEQ, 1, 32'h1C00, 32'h0,    1, 0, 2'b01, 32'h0);
        add(0, 1, T_IDLE, 0, 32'h0,    32'hDEAD, 1, 1, 2'b01, 32'h0);
        add(0, 1, T_NSEQ, 1, 32'h1A02, 32'hDEAD, 1, 0, 2'b01, 32'h0);
        add(0, 1, T_IDLE, 0, 32'h0,    32'hBEEF, 1, 1, 2'b01, 32'h0);
        add(0, 1, T_NSEQ, 0, 32'h1A00, 32'h0,    1, 1, 2'b00, 32'h1);
        // Not accepted: hready_i low, BUSY, IDLE, deselected.
        add(0, 1, T_NSEQ, 1, 32'h1A00, 32'hBAD,  0, 1, 2'b00, 32'h0);
        add(0, 1, T_BUSY, 1, 32'h1A00, 32'hBAD,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_IDLE, 1, 32'h1A00, 32'hBAD,  1, 1, 2'b00, 32'h0);
        add(0, 0, T_NSEQ, 1, 32'h1A00, 32'hBAD,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_NSEQ, 0, 32'h1A00, 32'hBAD,  1, 1, 2'b00, 32'h1);
        add(0, 1, T_IDLE, 0, 32'h0,    32'h0,    1, 1, 2'b00, 32'h0);
        // Window edges: below base errors, last word is valid.
        add(0, 1, T_NSEQ, 0, 32'h19FC, 32'h0,  1, 0, 2'b01, 32'h0);
        add(0, 1, T_IDLE, 0, 32'h0,    32'h0,  1, 1, 2'b01, 32'h0);
        add(0, 1, T_IDLE, 0, 32'h0,    32'h0,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_NSEQ, 1, 32'h1BFC, 32'h0,  1, 1, 2'b00, 32'h0);
        add(0, 1, T_NSEQ, 0, 32'h1BFC, 32'h77, 1, 1, 2'b00, 32'h77);
        add(0, 1, T_IDLE, 0, 32'h0,    32'h0,  1, 1, 2'b00, 32'h0);

        // One wait state: write burst to 0x1B00 then read it back.
        add(1, 1, T_NSEQ, 1, 32'h1B00, 32'h0,  1, 0, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  1, 32'h1B04, 32'hA0, 0, 1, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  1, 32'h1B04, 32'hA0, 1, 0, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  1, 32'h1B08, 32'hA1, 0, 1, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  1, 32'h1B08, 32'hA1, 1, 0, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  1, 32'h1B0C, 32'hA2, 0, 1, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  1, 32'h1B0C, 32'hA2, 1, 0, 2'b00, 32'h0);
        add(1, 1, T_IDLE, 0, 32'h0,    32'hA3, 0, 1, 2'b00, 32'h0);
        add(1, 1, T_IDLE, 0, 32'h0,    32'hA3, 1, 1, 2'b00, 32'h0);
        add(1, 1, T_NSEQ, 0, 32'h1B00, 32'h0,  1, 0, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  0, 32'h1B04, 32'h0,  0, 1, 2'b00, 32'hA0);
        add(1, 1, T_SEQ,  0, 32'h1B04, 32'h0,  1, 0, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  0, 32'h1B08, 32'h0,  0, 1, 2'b00, 32'hA1);
        add(1, 1, T_SEQ,  0, 32'h1B08, 32'h0,  1, 0, 2'b00, 32'h0);
        add(1, 1, T_SEQ,  0, 32'h1B0C, 32'h0,  0, 1, 2'b00, 32'hA2);
        add(1, 1, T_SEQ,  0, 32'h1B0C, 32'h0,  1, 0, 2'b00, 32'h0);
        add(1, 1, T_IDLE, 0, 32'h0,    32'h0,  0, 1, 2'b00, 32'hA3);
        add(1, 1, T_IDLE, 0, 32'h0,    32'h0,  1, 1, 2'b00, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // Reset in the middle of a write's wait state must drop the write.
        v.dut = 1; v.sel = 1; v.tr = T_NSEQ; v.wr = 1; v.addr = 32'h1B00; v.wd = 32'h0;
        v.rdy = 1; v.e_rdy = 0; v.e_resp = 2'b00; v.e_rd = 32'h0;
        step(v, "rst_wait_enter");
        d_tr = T_IDLE; d_sel = 1'b0; d_wd = 32'h99;
        #2;
        irst_n = 1'b0;
        #1;
        check("rst_async", 1'b1, 2'b00, 32'h0);
        @(posedge hclk);
        #1;
        check("rst_held", 1'b1, 2'b00, 32'h0);
        irst_n = 1'b1;
        v.tr = T_NSEQ; v.wr = 0; v.addr = 32'h1B00; v.wd = 32'h0;
        v.rdy = 1; v.e_rdy = 0; v.e_resp = 2'b00; v.e_rd = 32'h0;
        step(v, "rst_rd_addr");
        v.tr = T_IDLE; v.rdy = 0; v.e_rdy = 1; v.e_rd = 32'hA0;
        step(v, "rst_rd_data");
        v.rdy = 1; v.e_rdy = 1; v.e_rd = 32'h0;
        step(v, "rst_rd_idle");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
